// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/count engine.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_t;

    localparam int CSEC_MAX = 99;
    localparam int DISP_W   = 14;

    // Packs seconds and centiseconds into the sec*100 + csec display value.
    function automatic logic [DISP_W-1:0] to_disp(input logic [6:0] sec, input logic [6:0] csec);
        return DISP_W'(sec) * DISP_W'(100) + DISP_W'(csec);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// A held button yields a single one-cycle pulse.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Stopwatch STOP/RUN/CLEAR sequencer, tick divider, csec/sec counters and display register.
// Define STOPWATCH_LAP_EN to add the btn_lap input and the lap-hold display freeze.
module stopwatch_run_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_SEC = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_run,
    input  logic              btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic              btn_lap,
`endif
    output logic [DISP_W-1:0] disp_val,
    output logic [1:0]        state,
    output logic              run_led
);

    localparam int DIV_N = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_N - 1);
    localparam logic [6:0]       SEC_LAST  = 7'(MAX_SEC - 1);
    localparam logic [6:0]       CSEC_LAST = 7'(CSEC_MAX);

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
    logic [NUM_BTN-1:0] btn_raw;
    assign btn_raw = {btn_lap, btn_clear, btn_run};
`else
    localparam int NUM_BTN = 2;
    logic [NUM_BTN-1:0] btn_raw;
    assign btn_raw = {btn_clear, btn_run};
`endif

    logic [NUM_BTN-1:0] btn_pulse;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_edge u_btn_edge (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    logic run_pulse;
    logic clear_pulse;
    assign run_pulse   = btn_pulse[0];
    assign clear_pulse = btn_pulse[1];

    sw_state_t         state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [6:0]        csec_reg, csec_next;
    logic [6:0]        sec_reg, sec_next;
    logic [DISP_W-1:0] disp_val_reg, disp_val_next;
    logic              lap_hold_reg, lap_hold_next;
    logic              tick;

    assign tick = (state_reg == ST_RUN) && (div_reg == DIV_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_STOP: begin
                if (clear_pulse)    state_next = ST_CLEAR;
                else if (run_pulse) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (run_pulse) state_next = ST_STOP;
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    // Divider only advances in RUN, so a resume continues the sub-tick phase.
    always_comb begin
        div_next  = div_reg;
        csec_next = csec_reg;
        sec_next  = sec_reg;
        if (state_reg == ST_CLEAR) begin
            div_next  = '0;
            csec_next = '0;
            sec_next  = '0;
        end else if (state_reg == ST_RUN) begin
            if (tick) begin
                div_next = '0;
                if (csec_reg == CSEC_LAST) begin
                    csec_next = '0;
                    sec_next  = (sec_reg == SEC_LAST) ? 7'd0 : sec_reg + 7'd1;
                end else begin
                    csec_next = csec_reg + 7'd1;
                end
            end else begin
                div_next = div_reg + DIV_W'(1);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_comb begin
        lap_hold_next = lap_hold_reg;
        if (state_reg == ST_CLEAR)
            lap_hold_next = 1'b0;
        else if (state_reg == ST_RUN && btn_pulse[2])
            lap_hold_next = ~lap_hold_reg;
    end
`else
    assign lap_hold_next = 1'b0;
`endif

    assign disp_val_next = lap_hold_reg ? disp_val_reg : to_disp(sec_reg, csec_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_STOP;
            div_reg      <= '0;
            csec_reg     <= '0;
            sec_reg      <= '0;
            disp_val_reg <= '0;
            lap_hold_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            csec_reg     <= csec_next;
            sec_reg      <= sec_next;
            disp_val_reg <= disp_val_next;
            lap_hold_reg <= lap_hold_next;
        end
    end

    assign disp_val = disp_val_reg;
    assign state    = state_reg;
    assign run_led  = (state_reg == ST_RUN);

endmodule
